// File: rtl/bist_tpg.sv
// BIST test-pattern generator: runtime-programmable internal-XOR LFSR emitting a counted run.
// Define BIST_TPG_ALL_ZERO_EN to append a single all-zero pattern after the LFSR sequence.
module bist_tpg #(
  parameter int unsigned N     = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             hold,
  input  logic [N-1:0]     poly,
  input  logic [N-1:0]     seed,
  input  logic [CNT_W-1:0] num_patterns,
  output logic [N-1:0]     pattern,
  output logic             pattern_valid,
  output logic             busy,
  output logic             done
);

`ifdef BIST_TPG_ALL_ZERO_EN
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_ZERO, S_DONE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
`endif

  state_t           state_q;
  logic [N-1:0]     poly_q;
  logic [CNT_W-1:0] num_q;
  logic [CNT_W-1:0] cnt_q;
  logic [N-1:0]     pattern_q;
  logic [N-1:0]     lfsr_d;
  logic             busy_q;
  logic             done_q;
  logic             last_run;

  always_comb begin
    lfsr_d = '0;
    lfsr_d[N-1] = pattern_q[0] & poly_q[N-1];
    for (int unsigned i = 0; i < N - 1; i++) begin
      lfsr_d[i] = (pattern_q[0] & poly_q[i]) ^ pattern_q[i+1];
    end
  end

  assign last_run = (cnt_q == (num_q - CNT_W'(1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      poly_q    <= '0;
      num_q     <= '0;
      cnt_q     <= '0;
      pattern_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            poly_q    <= poly;
            num_q     <= num_patterns;
            cnt_q     <= '0;
            pattern_q <= (seed == '0) ? N'(1) : seed;
            if (num_patterns == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_RUN;
              busy_q  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (!hold) begin
            // the final LFSR pattern stays on the bus rather than advancing past it
            if (last_run) begin
`ifdef BIST_TPG_ALL_ZERO_EN
              state_q   <= S_ZERO;
              pattern_q <= '0;
`else
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
`endif
            end else begin
              cnt_q     <= cnt_q + CNT_W'(1);
              pattern_q <= lfsr_d;
            end
          end
        end
`ifdef BIST_TPG_ALL_ZERO_EN
        S_ZERO: begin
          if (!hold) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
`endif
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign pattern       = pattern_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pattern_valid = busy_q & ~hold;

endmodule

// File: doc/bist_tpg.md
BIST_TPG -- requirements
Module: bist_tpg

Interface
REQ-001 The block SHALL have parameter N, default 8, giving the pattern/LFSR width in bits (N >= 2).
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the pattern-count width in bits.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port start, input, 1, request to begin a pattern run; sampled only in IDLE.
REQ-006 The block SHALL have port hold, input, 1, stall from consumer; freezes pattern and count while high.
REQ-007 The block SHALL have port poly, input, N, feedback polynomial taps; latched at start.
REQ-008 The block SHALL have port seed, input, N, initial LFSR value; latched at start.
REQ-009 The block SHALL have port num_patterns, input, CNT_W, number of LFSR patterns to emit; latched at start.
REQ-010 The block SHALL have port pattern, output, N, registered test pattern driven to CUT.
REQ-011 The block SHALL have port pattern_valid, output, 1, high when pattern is emitted this cycle; drives compactor enable.
REQ-012 The block SHALL have port busy, output, 1, high in RUN and ZERO states.
REQ-013 The block SHALL have port done, output, 1, single-cycle pulse at end of run.

Function
REQ-014 The FSM SHALL have states IDLE, RUN, ZERO, DONE; ZERO is reachable only per REQ-030.
REQ-015 In IDLE, start=1 at an edge SHALL latch poly, seed and num_patterns, clear count, and load pattern with seed (or 1 if seed==0); next state RUN, or DONE if num_patterns==0.
REQ-016 pattern_valid SHALL equal (state==RUN or state==ZERO) AND NOT hold, derived from registered state and hold.
REQ-017 In RUN with hold=0, each edge SHALL advance pattern q by a right-shift internal-XOR step: q[N-1] <= q[0]&poly[N-1]; q[i] <= (q[0]&poly[i]) ^ q[i+1] for i < N-1.
REQ-018 In RUN with hold=0, count SHALL increment by 1 per emitted pattern; when count == num_patterns-1 the state SHALL leave RUN at that edge.
REQ-019 With hold=1, pattern, count and state SHALL be unchanged and pattern_valid SHALL be 0.
REQ-020 Exactly num_patterns valid cycles SHALL occur in RUN; first valid pattern equals the loaded seed.
REQ-021 DONE SHALL last exactly one cycle with done=1, busy=0, pattern_valid=0, then return to IDLE.
REQ-022 start SHALL be ignored in RUN, ZERO and DONE; no queuing.
REQ-023 pattern SHALL hold its last value in DONE and IDLE until the next accepted start.
REQ-024 num_patterns larger than the LFSR period SHALL be honoured; sequence wraps and repeats.
REQ-025 poly, seed, num_patterns changes after start SHALL not affect the run in progress.

Reset
REQ-026 rst=1 at an edge SHALL force state IDLE, pattern=0, count=0, pattern_valid=0, busy=0, done=0, overriding all other inputs.
REQ-027 rst asserted mid-run SHALL abort the run with no done pulse; outputs take reset values the following cycle.
REQ-028 start coincident with rst SHALL be ignored.

Configuration
REQ-029 Macro BIST_TPG_ALL_ZERO_EN SHALL select the all-zero pattern extension.
REQ-030 With BIST_TPG_ALL_ZERO_EN defined, leaving RUN after the last LFSR pattern SHALL enter ZERO with pattern=0, emit it for one valid cycle (respecting hold), then go to DONE; num_patterns==0 still goes straight to DONE.
REQ-031 Without BIST_TPG_ALL_ZERO_EN, ZERO SHALL not exist; RUN goes directly to DONE.

Verification (N=4, poly=4'hC unless noted)
REQ-032 seed=4'h1, num_patterns=5, hold=0, start one cycle -> pattern_valid high 5 cycles with pattern 1,C,6,3,D; done pulses next cycle; busy low thereafter.
REQ-033 seed=4'h1, num_patterns=15 -> 1,C,6,3,D,A,5,E,7,F,B,9,8,4,2 then done; with BIST_TPG_ALL_ZERO_EN a 16th valid pattern 0 precedes done.
REQ-034 num_patterns=5, hold high for 2 cycles while pattern=6 -> pattern stays 6, pattern_valid 0 for those cycles, then 6,3,D emitted; total valid count still 5.
REQ-035 seed=4'h0, num_patterns=2 -> patterns 1,C; num_patterns=0 -> no valid cycles, done pulses the cycle after start.
REQ-036 rst during 3rd pattern -> next cycle all outputs 0, no done; start pulsed while busy -> ignored, pattern sequence unaffected.
